// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-stage controller: access sizes, FSM states
// and the big-endian lane helpers used when a request is launched.
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Offset 0 is the MSB lane (bit 3); the reserved size code behaves as a word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b1000 >> offset;
            SIZE_HALF: mask = offset[1] ? 4'b0011 : 4'b1100;
            default:   mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~offset[0];
            default:   ok = (offset == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wdata;
        case (size)
            SIZE_BYTE: wdata = {4{data[7:0]}};
            SIZE_HALF: wdata = {2{data[15:0]}};
            default:   wdata = data;
        endcase
        return wdata;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory-stage controller (master) and the memory (slave).
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byte_en;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_byte_en, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_byte_en, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Big-endian load aligner: selects the addressed byte/halfword of a bus word
// and sign- or zero-extends it to 32 bits.
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[31:24];
        case (i_offset)
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            2'd3:    w_byte = i_rdata[7:0];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[15:0] : i_rdata[31:16];

        case (i_size)
            SIZE_BYTE: o_result = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SIZE_HALF: o_result = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default:   o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: launches handshaked bus transfers for DLX loads and
// stores, stalls the pipeline while they are in flight, and flags faults.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [1:0]         i_mem_size,
    input  logic               i_mem_unsigned,
    input  logic [31:0]        i_address,
    input  logic [31:0]        i_store_data,
    output logic [31:0]        o_data_from_mem,
    output logic               o_mem_stall,
    output logic               o_mem_fault,
    mem_access_unit_if.master  bus
);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bus_req;
    logic               r_bus_we;
    logic [31:0]        r_bus_addr;
    logic [3:0]         r_bus_be;
    logic [31:0]        r_bus_wdata;
    logic               r_fault;
    logic [31:0]        r_data;
    logic               r_is_read;
    logic [1:0]         r_size;
    logic [1:0]         r_offset;
    logic               r_unsigned;

    logic               w_access;
    logic               w_ok;
    logic               w_timeout;
    logic [31:0]        w_load_data;

    assign w_access  = i_mem_read | i_mem_write;
    assign w_ok      = w_access & is_aligned(i_mem_size, i_address[1:0]);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    load_align u_load_align (
        .i_rdata    (bus.bus_rdata),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_result   (w_load_data)
    );

    always_comb begin
        w_next_state = r_state;
        o_mem_stall  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_mem_stall = w_ok;
                if (w_ok) w_next_state = ST_REQ;
            end
            ST_REQ: begin
                o_mem_stall = 1'b1;
                if (bus.bus_ack || w_timeout) w_next_state = ST_DONE;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Bus fields are captured once at launch and held untouched through REQ.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_fault     <= 1'b0;
            r_data      <= '0;
            r_is_read   <= 1'b0;
            r_size      <= '0;
            r_offset    <= '0;
            r_unsigned  <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ok) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= i_mem_write & ~i_mem_read;
                        r_bus_addr  <= {i_address[31:2], 2'b00};
                        r_bus_be    <= lane_mask(i_mem_size, i_address[1:0]);
                        r_bus_wdata <= replicate_store(i_mem_size, i_store_data);
                        r_is_read   <= i_mem_read;
                        r_size      <= i_mem_size;
                        r_offset    <= i_address[1:0];
                        r_unsigned  <= i_mem_unsigned;
                        r_cnt       <= '0;
                    end else if (w_access) begin
                        r_fault <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_ack) begin
                        r_bus_req <= 1'b0;
                        if (r_is_read) r_data <= w_load_data;
                    end else if (w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_data    <= '0;
                        r_fault   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_req     = r_bus_req;
    assign bus.bus_we      = r_bus_we;
    assign bus.bus_addr    = r_bus_addr;
    assign bus.bus_byte_en = r_bus_be;
    assign bus.bus_wdata   = r_bus_wdata;
    assign o_data_from_mem = r_data;
    assign o_mem_fault     = r_fault;

endmodule
